// File: rtl/ram_refresh_gen_if.sv
// ram_refresh_gen_if: DRAM strobes in, refresh request/urgency/debt status out.
interface ram_refresh_gen_if;
  logic       nRAS;
  logic       nCAS;
  logic       RefReq;
  logic       RefUrg;
  logic [2:0] RefDebt;
  logic       RefOvf;
  modport master (output nRAS, nCAS, input RefReq, RefUrg, RefDebt, RefOvf);
  modport slave  (input nRAS, nCAS, output RefReq, RefUrg, RefDebt, RefOvf);
endinterface

// File: rtl/ram_refresh_gen.sv
// ram_refresh_gen: owes one refresh per PERIOD, retires debt on sampled CAS-before-RAS
// cycles, and masks requests for HOLD cycles after each retired refresh.
module ram_refresh_gen #(
  parameter int PERIOD   = 384,
  parameter int URG_DEBT = 2,
  parameter int MAX_DEBT = 7,
  parameter int HOLD     = 4
) (
  input logic CLK,
  input logic RST,
  ram_refresh_gen_if.slave bus
);
  localparam int IW = $clog2(PERIOD);
  localparam int HW = $clog2(HOLD + 1);
  logic [IW-1:0] ic;
  logic [HW-1:0] hc, hc_next;
  logic [2:0] debt, debt_next;
  logic s_ras, s_cas, p_ras, req, urg, ovf, tick, rf, sat;
  assign tick = ic == IW'(PERIOD - 1);
  assign rf = p_ras & ~s_ras & ~s_cas;
  assign sat = debt == 3'(MAX_DEBT);
  // a tick and a refresh on the same edge cancel out
  always_comb begin
    debt_next = tick & ~rf ? (sat ? debt : debt + 3'd1) :
                rf & ~tick & (debt != 3'd0) ? debt - 3'd1 : debt;
    hc_next = rf ? HW'(HOLD) : (hc != '0) ? hc - HW'(1) : hc;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ic    <= '0;
      debt  <= '0;
      hc    <= '0;
      s_ras <= 1'b1;
      s_cas <= 1'b1;
      p_ras <= 1'b1;
      req   <= 1'b0;
      urg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ic    <= tick ? '0 : ic + IW'(1);
      debt  <= debt_next;
      hc    <= hc_next;
      s_ras <= bus.nRAS;
      s_cas <= bus.nCAS;
      p_ras <= s_ras;
      req   <= (debt_next != 3'd0) && (hc_next == '0);
      urg   <= (debt_next >= 3'(URG_DEBT)) && (hc_next == '0);
      ovf   <= ovf | (tick & ~rf & sat);
    end
  end
  assign bus.RefReq  = req;
  assign bus.RefUrg  = urg;
  assign bus.RefDebt = debt;
  assign bus.RefOvf  = ovf;
endmodule

// File: tb/tb_ram_refresh_gen.sv
// tb_ram_refresh_gen: directed edge-by-edge checks of tick, retire, hold, saturation and reset.
module tb_ram_refresh_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  ram_refresh_gen_if bus ();
  ram_refresh_gen #(.PERIOD(8), .URG_DEBT(2), .MAX_DEBT(7), .HOLD(4)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic req, input logic urg, input logic [2:0] debt);
    chk({tag, "_req"}, {3'd0, bus.RefReq}, {3'd0, req});
    chk({tag, "_urg"}, {3'd0, bus.RefUrg}, {3'd0, urg});
    chk({tag, "_debt"}, {1'b0, bus.RefDebt}, {1'b0, debt});
  endtask
  task automatic release_rst();
    rst = 1'b0;
    edge_n = 0;
  endtask
  initial begin
    bus.nRAS = 1'b1;
    bus.nCAS = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 3'd0);
    chk("reset_ovf", {3'd0, bus.RefOvf}, 4'd0);
    release_rst();
    step_to(7);
    chk_out("pre_tick", 1'b0, 1'b0, 3'd0);
    step_to(8);
    chk_out("tick1", 1'b1, 1'b0, 3'd1);
    // normal access: RAS seen low at 9, CAS at 11, both high at 14
    bus.nRAS = 1'b0;
    for (int e = 9; e <= 14; e++) begin
      step_to(e);
      chk_out($sformatf("normal_e%0d", e), 1'b1, 1'b0, 3'd1);
      if (e == 10) bus.nCAS = 1'b0;
      if (e == 13) begin bus.nRAS = 1'b1; bus.nCAS = 1'b1; end
    end
    step_to(16);
    chk_out("tick2", 1'b1, 1'b1, 3'd2);
    // refresh: both strobes first seen low at E=17, rf at 18
    bus.nRAS = 1'b0;
    bus.nCAS = 1'b0;
    step_to(17);
    chk_out("retire_E", 1'b1, 1'b1, 3'd2);
    step_to(18);
    chk_out("retire_E1", 1'b0, 1'b0, 3'd1);
    bus.nRAS = 1'b1;
    bus.nCAS = 1'b1;
    for (int e = 19; e <= 21; e++) begin
      step_to(e);
      chk_out($sformatf("hold_e%0d", e), 1'b0, 1'b0, 3'd1);
    end
    step_to(22);
    chk_out("retire_E5", 1'b1, 1'b0, 3'd1);
    // rf lands on the tick edge 24
    bus.nRAS = 1'b0;
    bus.nCAS = 1'b0;
    step_to(24);
    chk_out("simul", 1'b0, 1'b0, 3'd1);
    chk("simul_ovf", {3'd0, bus.RefOvf}, 4'd0);
    bus.nRAS = 1'b1;
    bus.nCAS = 1'b1;
    step_to(27);
    chk_out("simul_hold", 1'b0, 1'b0, 3'd1);
    step_to(28);
    chk_out("simul_end", 1'b1, 1'b0, 3'd1);
    step_to(40);
    chk_out("debt3", 1'b1, 1'b1, 3'd3);
    bus.nRAS = 1'b0;
    bus.nCAS = 1'b0;
    step_to(42);
    chk_out("rf_debt3", 1'b0, 1'b0, 3'd2);
    step_to(44);
    rst = 1'b1;
    bus.nRAS = 1'b1;
    bus.nCAS = 1'b1;
    #1;
    chk_out("rst_mid", 1'b0, 1'b0, 3'd0);
    chk("rst_mid_ovf", {3'd0, bus.RefOvf}, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    release_rst();
    step_to(7);
    chk_out("rst_pre", 1'b0, 1'b0, 3'd0);
    step_to(8);
    chk_out("rst_first", 1'b1, 1'b0, 3'd1);
    step_to(55);
    chk_out("sat_pre", 1'b1, 1'b1, 3'd6);
    step_to(56);
    chk_out("sat", 1'b1, 1'b1, 3'd7);
    step_to(63);
    chk("ovf_pre", {3'd0, bus.RefOvf}, 4'd0);
    step_to(64);
    chk("ovf", {3'd0, bus.RefOvf}, 4'd1);
    chk("ovf_debt", {1'b0, bus.RefDebt}, 4'd7);
    step_to(72);
    chk("ovf_sticky", {3'd0, bus.RefOvf}, 4'd1);
    chk("ovf_debt2", {1'b0, bus.RefDebt}, 4'd7);
    rst = 1'b1;
    #1;
    chk("ovf_rst", {3'd0, bus.RefOvf}, 4'd0);
    chk_out("final_rst", 1'b0, 1'b0, 3'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
